step_mod_counter: RTL and testbench
===================================

# step_mod_counter

Parametrised modulo counter with selectable step size (1/2/4/8), direction control, synchronous load and a Mealy terminal-count output. It is the generalised successor of the fixed 4-bit, x-gated counter in the sequential-logic lab set. It is used wherever a datapath needs a programmable-stride address or phase counter with a wrap indication. It also keeps a saturating wrap tally for debug and verification.

## Interface
Parameters:
- WIDTH, 4: counter width in bits.
- MOD, 16: counting modulus; legal range 8 ≤ MOD ≤ 2**WIDTH, enforced by an elaboration-time check.
- WRAP_W, 8: width of the saturating wrap tally.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 holds the state.
- mode  in  2  step select; step = 1 << mode, giving 1, 2, 4 or 8.
- dir  in  1  1 = up, 0 = down.
- load  in  1  synchronous load; has priority over en.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  registered count, always in 0..MOD-1.
- z  out  1  combinational; high when this cycle's count step wraps.
- wraps  out  WRAP_W  registered saturating count of wraps.
- err  out  1  registered one-cycle pulse on an out-of-range load.

## Operation
- Reset, asynchronous, with rst high: q=0, wraps=0, err=0.
  - z is then 0, because the reset state forces the internal wrap term low.
  - Deassertion takes effect at the next clk edge.
- Next-value arithmetic is done in WIDTH+1 bits so no intermediate value overflows.
  - Up: s = q + step. If s ≥ MOD, then next = s − MOD and wrap=1. Otherwise next = s and wrap=0.
  - Down: if q ≥ step, then next = q − step and wrap=0. Otherwise next = q + MOD − step and wrap=1.
- Per-cycle priority: load, then en, then hold.
  - load=1 with load_val < MOD: q ← load_val, wraps ← 0, err ← 0.
  - load=1 with load_val ≥ MOD: q ← MOD−1, wraps ← 0, err ← 1 for exactly one cycle.
  - load=0, en=1: q ← next. If wrap=1 and wraps ≠ all-ones, wraps ← wraps+1.
  - load=0, en=0: q, wraps unchanged, err ← 0.
- z = en & ~load & wrap.
  - Mealy output: it is asserted during the cycle before the edge that wraps q.
- mode and dir are sampled every cycle; changing them mid-count takes effect on the next edge with no pipeline delay.
- wraps saturates at 2**WRAP_W − 1 and never rolls over.

## Timing
- q latency: 1 clk from en/load/mode/dir to the updated q.
- z: purely combinational from q, en, load, mode and dir; no register stage.
- err: valid the cycle after the load edge, cleared on the following edge.
- Reset mid-operation: all registers clear immediately. Any load or count on the edge where rst is high is discarded.
- Boundary: with MOD=8 and step=8, every enabled step wraps. q stays unchanged and z=1 every enabled cycle.

## Structure
- Shared package step_cnt_pkg holds:
  - the mode encodings STEP_1=2'b00, STEP_2=2'b01, STEP_4=2'b10, STEP_8=2'b11;
  - the direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- One combinational sub-module, mod_step_adder (q, step, dir → next, wrap), parametrised by WIDTH and MOD.
  - It is reused by the bench scoreboard as the reference model.
- The top level holds the q/wraps/err registers, the load/enable priority mux and the z gating.

## Test plan
- Up-count: WIDTH=4, MOD=10, mode=2 (step 4), dir=1, en=1 from reset.
  - Required: q = 0, 4, 8, 2, 6.
  - z=1 only in the cycle where q=8; wraps=1 after the third edge.
- Down-count: MOD=10, mode=1 (step 2), dir=0, load_val=1, then enable.
  - Required: q = 1, 9, 7, …; z=1 in the cycle where q=1.
- Load priority and range: MOD=10, load=1 with load_val=12 and en=1.
  - Required: q=9, err=1 for one cycle, wraps=0.
  - Then load_val=3 gives q=3 and err=0.
- Hold and mid-count changes: en=0 for 3 cycles freezes q and keeps z=0.
  - Then switching dir and mode on consecutive cycles steps q with the new values on the very next edge.
- Saturation: WRAP_W=2, MOD=8, mode=3, en=1 for 6 cycles.
  - Required: wraps = 1, 2, 3, 3, 3, 3; q stays constant; z held at 1.
- Async reset: assert rst between clk edges mid-count.
  - Required: q, wraps and err read 0 immediately, before the next edge.
  - After release, the first enabled edge gives q = step (up) or MOD − step (down).

Source files
------------

// File: rtl/step_mod_counter_pkg.sv
// Shared constants for the step/modulo counter.
//   STEP_*  : mode encodings, step = 1 << mode
//   DIR_*   : direction select values
//   step_of : mode -> step size (1/2/4/8)
package step_cnt_pkg;
  localparam logic [1:0] STEP_1 = 2'b00;
  localparam logic [1:0] STEP_2 = 2'b01;
  localparam logic [1:0] STEP_4 = 2'b10;
  localparam logic [1:0] STEP_8 = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic [3:0] step_of(input logic [1:0] mode);
    case (mode)
      STEP_1:  step_of = 4'd1;
      STEP_2:  step_of = 4'd2;
      STEP_4:  step_of = 4'd4;
      default: step_of = 4'd8;
    endcase
  endfunction
endpackage

// File: rtl/step_mod_counter_if.sv
// Control/status bundle of the step/modulo counter.
//   master : drives en/mode/dir/load/load_val, observes q/z/wraps/err
//   slave  : the counter itself
interface step_mod_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              en;
  logic [1:0]        mode;
  logic              dir;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  q;
  logic              z;
  logic [WRAP_W-1:0] wraps;
  logic              err;

  modport master (output en, mode, dir, load, load_val,
                  input  q, z, wraps, err);
  modport slave  (input  en, mode, dir, load, load_val,
                  output q, z, wraps, err);
endinterface

// File: rtl/step_mod_counter_adder.sv
// mod_step_adder: combinational modulo step.
//   q_i    : current count (0..MOD-1)
//   step_i : step size (1/2/4/8)
//   dir_i  : DIR_UP / DIR_DN
//   next_o : next count, wrapped into 0..MOD-1
//   wrap_o : the step crossed the modulus boundary
module mod_step_adder
  import step_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH:0]   step_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);
  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MOD);

  // One extra bit keeps q+step and q+MOD-step from overflowing.
  logic [WIDTH:0] qx, res;
  logic           unused_msb;

  always_comb begin
    qx     = {1'b0, q_i};
    res    = '0;
    wrap_o = 1'b0;
    if (dir_i == DIR_UP) begin
      res = qx + step_i;
      if (res >= MODV) begin
        res    = res - MODV;
        wrap_o = 1'b1;
      end
    end else if (qx >= step_i) begin
      res = qx - step_i;
    end else begin
      res    = qx + MODV - step_i;
      wrap_o = 1'b1;
    end
  end

  // Wrapped result is always below MOD, so the top bit is always zero.
  assign next_o     = res[WIDTH-1:0];
  assign unused_msb = res[WIDTH];
endmodule

// File: rtl/step_mod_counter.sv
// step_mod_counter: modulo counter with 1/2/4/8 stride, direction,
// synchronous load, Mealy wrap flag and a saturating wrap tally.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : step_mod_counter_if.slave (en, mode, dir, load, load_val -> q, z, wraps, err)
module step_mod_counter
  import step_cnt_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MOD    = 16,
  parameter int WRAP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  step_mod_counter_if.slave  bus
);
  generate
    if ((MOD < 8) || (MOD > (1 << WIDTH))) begin : g_bad_mod
      $error("step_mod_counter: MOD must satisfy 8 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0]  q_q, q_d, nxt;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;
  logic [WIDTH:0]    step;
  logic              wrap, wrap_live;

  assign step = (WIDTH+1)'(step_of(bus.mode));

  mod_step_adder #(.WIDTH(WIDTH), .MOD(MOD)) u_add (
    .q_i   (q_q),
    .step_i(step),
    .dir_i (bus.dir),
    .next_o(nxt),
    .wrap_o(wrap)
  );

  // Held in reset, the wrap term is forced low so z reads 0 even for
  // configurations where q=0 would otherwise wrap (e.g. counting down).
  assign wrap_live = wrap & ~rst;

  always_comb begin
    q_d     = q_q;
    wraps_d = wraps_q;
    err_d   = 1'b0;
    if (bus.load) begin
      wraps_d = '0;
      if ({1'b0, bus.load_val} < MODV) begin
        q_d = bus.load_val;
      end else begin
        q_d   = QMAX;
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      q_d = nxt;
      if (wrap && (wraps_q != '1))
        wraps_d = wraps_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      wraps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      wraps_q <= wraps_d;
      err_q   <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.wraps = wraps_q;
  assign bus.err   = err_q;
  assign bus.z     = bus.en & ~bus.load & wrap_live;
endmodule

// File: tb/tb_step_mod_counter.sv
module tb_step_mod_counter;
  logic clk, rst;
  int   tests, fails;

  step_mod_counter_if #(.WIDTH(4), .WRAP_W(8)) ia ();
  step_mod_counter_if #(.WIDTH(4), .WRAP_W(2)) ib ();

  step_mod_counter #(.WIDTH(4), .MOD(10), .WRAP_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  step_mod_counter #(.WIDTH(4), .MOD(8),  .WRAP_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  logic [3:0] rq, rn;
  logic [4:0] rs;
  logic       rd, rw;
  mod_step_adder #(.WIDTH(4), .MOD(10)) u_ref (
    .q_i(rq), .step_i(rs), .dir_i(rd), .next_o(rn), .wrap_o(rw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ia.en = 1'b1; ia.mode = 2'd2; ia.dir = 1'b1; ia.load = 1'b0; ia.load_val = 4'd0;
    ib.en = 1'b1; ib.mode = 2'd3; ib.dir = 1'b1; ib.load = 1'b0; ib.load_val = 4'd0;
    rq = 4'd0; rs = 5'd1; rd = 1'b1;
    #12;
    // reset state
    chk("rst_q", ia.q, 0);
    chk("rst_wraps", ia.wraps, 0);
    chk("rst_err", ia.err, 0);
    chk("rst_z", ia.z, 0);
    chk("rst_zb_forced", ib.z, 0);

    // up-count MOD=10 step 4: 0,4,8,2,6
    rst = 1'b0; ib.en = 1'b0;
    #1;
    chk("up_q0", ia.q, 0);
    chk("up_z0", ia.z, 0);
    tick(); chk("up_q4", ia.q, 4);  chk("up_z4", ia.z, 0);
    tick(); chk("up_q8", ia.q, 8);  chk("up_z8", ia.z, 1); chk("up_w8", ia.wraps, 0);
    tick(); chk("up_q2", ia.q, 2);  chk("up_z2", ia.z, 0); chk("up_w2", ia.wraps, 1);
    tick(); chk("up_q6", ia.q, 6);

    // down-count step 2 from 1: 1,9,7
    ia.load = 1'b1; ia.load_val = 4'd1; ia.dir = 1'b0; ia.mode = 2'd1; ia.en = 1'b0;
    tick(); chk("dn_q1", ia.q, 1); chk("dn_wclr", ia.wraps, 0); chk("dn_err", ia.err, 0);
    ia.load = 1'b0; ia.en = 1'b1;
    #1; chk("dn_z1", ia.z, 1);
    tick(); chk("dn_q9", ia.q, 9); chk("dn_z9", ia.z, 0); chk("dn_w9", ia.wraps, 1);
    tick(); chk("dn_q7", ia.q, 7);

    // out-of-range load beats enable
    ia.load = 1'b1; ia.load_val = 4'd12;
    #1; chk("ld_z", ia.z, 0);
    tick(); chk("ld_bad_q", ia.q, 9); chk("ld_bad_err", ia.err, 1); chk("ld_bad_w", ia.wraps, 0);
    ia.load_val = 4'd3;
    tick(); chk("ld_ok_q", ia.q, 3); chk("ld_ok_err", ia.err, 0);

    // hold: q frozen, z low although the armed step would wrap
    ia.load = 1'b0; ia.en = 1'b0; ia.dir = 1'b1; ia.mode = 2'd3;
    #1; chk("hold_z", ia.z, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_q", ia.q, 3); chk("hold_zc", ia.z, 0);
    end

    // mid-count changes act on the very next edge
    ia.en = 1'b1; ia.dir = 1'b0; ia.mode = 2'd0;
    #1; chk("mid_z_dn1", ia.z, 0);
    tick(); chk("mid_q_dn1", ia.q, 2);
    ia.dir = 1'b1;
    tick(); chk("mid_q_up1", ia.q, 3);
    ia.mode = 2'd3;
    #1; chk("mid_z_up8", ia.z, 1);
    tick(); chk("mid_q_up8", ia.q, 1); chk("mid_w", ia.wraps, 1);

    // async reset between edges; edge during reset is discarded
    #3; rst = 1'b1;
    #1; chk("ar_q", ia.q, 0); chk("ar_w", ia.wraps, 0); chk("ar_z", ia.z, 0);
    ia.load = 1'b1; ia.load_val = 4'd5;
    tick(); chk("ar_hold_q", ia.q, 0);
    ia.load = 1'b0;
    #2; ia.dir = 1'b0; ia.mode = 2'd1; ia.en = 1'b1; rst = 1'b0;
    #1; chk("ar_rel_z", ia.z, 1);
    tick(); chk("ar_rel_q", ia.q, 8); chk("ar_rel_w", ia.wraps, 1);

    // async reset clears a pending err pulse
    ia.load = 1'b1; ia.load_val = 4'd15;
    tick(); chk("ar2_err_set", ia.err, 1);
    ia.load = 1'b0;
    #3; rst = 1'b1;
    #1; chk("ar2_err", ia.err, 0); chk("ar2_q", ia.q, 0);
    rst = 1'b0; ia.dir = 1'b1; ia.mode = 2'd2;
    tick(); chk("ar2_rel_q", ia.q, 4);

    // saturation: MOD=8, step 8, WRAP_W=2
    ib.en = 1'b1; ib.mode = 2'd3; ib.dir = 1'b1;
    #1; chk("sat_z0", ib.z, 1); chk("sat_q0", ib.q, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("sat_w", ib.wraps, (i > 3) ? 3 : i);
      chk("sat_q", ib.q, 0);
      chk("sat_z", ib.z, 1);
    end

    // reference adder, hand vectors
    rq = 4'd9; rs = 5'd2; rd = 1'b1;
    #1; chk("ref_up_n", rn, 1); chk("ref_up_w", rw, 1);
    rq = 4'd0; rs = 5'd8; rd = 1'b0;
    #1; chk("ref_dn_n", rn, 2); chk("ref_dn_w", rw, 1);
    rq = 4'd5; rs = 5'd4; rd = 1'b0;
    #1; chk("ref_dn2_n", rn, 1); chk("ref_dn2_w", rw, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
